// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random source: width limits, FSM states and
// the maximal-length tap table.
package lfsr_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 16;

  typedef enum logic {WARMUP, RUN} lfsr_state_t;

  // Bit i set means state bit i feeds the XOR that becomes the new bit 0.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      3:       lfsr_taps = 16'h0006;
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci LFSR step; an all-zero result is forced to 1 so
// the register can never lock up.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [15:0]      TAPS = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] MASK = TAPS[WIDTH-1:0];

  logic [WIDTH-1:0] raw;

  assign raw = {cur[WIDTH-2:0], ^(cur & MASK)};
  assign nxt = (raw == '0) ? WIDTH'(1) : raw;

endmodule

// File: rtl/lfsr_rand_gen.sv
// LFSR random source for cache random-replacement: seeded, warmed up, advanced
// STEPS positions per accepted request, and folded into a way index < NUMWAYS.
//
//   state  | meaning
//   WARMUP | free-running one step per cycle, Valid low
//   RUN    | Valid high, advance STEPS steps on each Req
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               STEPS      = 1,
  parameter int               WARMUP     = 4,
  parameter int               NUMWAYS    = 4,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
  parameter int               IDXW       = $clog2(NUMWAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Seed,
  input  logic             Load,
  input  logic             Req,
  output logic             Valid,
  output logic [WIDTH-1:0] RandOut,
  output logic [IDXW-1:0]  Index
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_rand_gen: WIDTH out of range 3..16");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_rand_gen: STEPS out of range 1..WIDTH");
  end
  if (NUMWAYS < 2 || NUMWAYS > (1 << WIDTH)) begin : g_bad_ways
    $error("lfsr_rand_gen: NUMWAYS out of range 2..2^WIDTH");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_rand_gen: RESET_SEED must be nonzero");
  end

  // Counter needs at least one bit even when warm-up is disabled.
  localparam int            CW        = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);

  lfsr_state_t      fsm;
  logic [CW-1:0]    warm_cnt;
  logic [WIDTH-1:0] state;
  logic             valid_q;
  logic [WIDTH-1:0] seed_fix;
  logic [WIDTH-1:0] chain [STEPS+1];

  assign seed_fix = (Seed == '0) ? WIDTH'(1) : Seed;
  assign chain[0] = state;

  for (genvar g = 0; g < STEPS; g++) begin : g_chain
    lfsr_step #(.WIDTH(WIDTH)) u_step (
      .cur (chain[g]),
      .nxt (chain[g+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_SEED;
      fsm      <= lfsr_pkg::WARMUP;
      warm_cnt <= '0;
      valid_q  <= 1'b0;
    end else if (Load) begin
      state    <= seed_fix;
      fsm      <= lfsr_pkg::WARMUP;
      warm_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (fsm)
        lfsr_pkg::WARMUP: begin
          if (WARMUP == 0) begin
            fsm     <= lfsr_pkg::RUN;
            valid_q <= 1'b1;
          end else begin
            state <= chain[1];
            if (warm_cnt == WARM_LAST) begin
              fsm     <= lfsr_pkg::RUN;
              valid_q <= 1'b1;
            end else begin
              warm_cnt <= warm_cnt + CW'(1);
            end
          end
        end
        lfsr_pkg::RUN: begin
          if (Req) state <= chain[STEPS];
        end
        default: begin
          fsm     <= lfsr_pkg::WARMUP;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NUMWAYS > 2^(IDXW-1), so one conditional subtraction folds the low bits in range.
  localparam logic [IDXW:0] NW = (IDXW + 1)'(NUMWAYS);

  logic [IDXW:0] idx_ext;
  logic [IDXW:0] idx_sub;

  assign idx_ext = {1'b0, state[IDXW-1:0]};
  assign idx_sub = idx_ext - NW;

  assign Valid   = valid_q;
  assign RandOut = state;
  assign Index   = (idx_ext >= NW) ? idx_sub[IDXW-1:0] : idx_ext[IDXW-1:0];

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Bench for lfsr_rand_gen: directed sequences on 4-bit instances, a randomized
// run against a reference model, and full-period sweeps for widths 3..16.
`timescale 1ns/1ps
module tb_lfsr_rand_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, per_reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   per_run  = 0;
  bit   per_done = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: shift left, new bit 0 = XOR of the listed tap positions.
  function automatic int ref_step(input int w, input int s);
    int taps[$];
    int fb = 0;
    int nx;
    case (w)
      4:       taps = '{3, 2};
      8:       taps = '{7, 5, 4, 3};
      default: taps = '{};
    endcase
    foreach (taps[t]) fb ^= (s >> taps[t]) & 1;
    nx = ((s << 1) % (1 << w)) | fb;
    return (nx == 0) ? 1 : nx;
  endfunction

  function automatic int ref_idx(input int v, input int idxw, input int nw);
    int i = v % (1 << idxw);
    return (i >= nw) ? i - nw : i;
  endfunction

  // A: 4-bit, 1 step, no warm-up, 3 ways
  logic [3:0] a_seed, a_ro; logic a_load, a_req, a_v; logic [1:0] a_idx;
  lfsr_rand_gen #(.WIDTH(4), .STEPS(1), .WARMUP(0), .NUMWAYS(3)) u_a (
    .clk(clk), .reset(reset), .Seed(a_seed), .Load(a_load), .Req(a_req),
    .Valid(a_v), .RandOut(a_ro), .Index(a_idx));

  // B: 4-bit, 2 steps, no warm-up, 4 ways
  logic [3:0] b_seed, b_ro; logic b_load, b_req, b_v; logic [1:0] b_idx;
  lfsr_rand_gen #(.WIDTH(4), .STEPS(2), .WARMUP(0), .NUMWAYS(4)) u_b (
    .clk(clk), .reset(reset), .Seed(b_seed), .Load(b_load), .Req(b_req),
    .Valid(b_v), .RandOut(b_ro), .Index(b_idx));

  // C: 4-bit, 3-cycle warm-up
  logic [3:0] c_seed, c_ro; logic c_load, c_req, c_v; logic [1:0] c_idx;
  lfsr_rand_gen #(.WIDTH(4), .STEPS(1), .WARMUP(3), .NUMWAYS(4)) u_c (
    .clk(clk), .reset(reset), .Seed(c_seed), .Load(c_load), .Req(c_req),
    .Valid(c_v), .RandOut(c_ro), .Index(c_idx));

  // D: 8-bit, 3 steps, 4-cycle warm-up, 5 ways, randomized
  logic [7:0] d_seed, d_ro; logic d_load, d_req, d_v; logic [2:0] d_idx;
  lfsr_rand_gen #(.WIDTH(8), .STEPS(3), .WARMUP(4), .NUMWAYS(5),
                  .RESET_SEED(8'h5A)) u_d (
    .clk(clk), .reset(reset), .Seed(d_seed), .Load(d_load), .Req(d_req),
    .Valid(d_v), .RandOut(d_ro), .Index(d_idx));

  // Full-period sweep, Req held high from reset release
  for (genvar w = 3; w <= 16; w++) begin : g_per
    logic [w-1:0] ro;
    logic         v;
    logic [1:0]   idx;
    bit           seen [2**w];
    int           n = 0, first_ret = 0, rep_val = -1, imax = 0;
    bit           zero_seen = 0;

    lfsr_rand_gen #(.WIDTH(w), .STEPS(1), .WARMUP(0), .NUMWAYS(3)) u_dut (
      .clk(clk), .reset(per_reset), .Seed({w{1'b0}}), .Load(1'b0), .Req(1'b1),
      .Valid(v), .RandOut(ro), .Index(idx));

    always @(negedge clk) begin
      if (per_run && v && first_ret == 0) begin
        if (ro == 0) zero_seen = 1;
        if (seen[ro]) begin
          first_ret = n;
          rep_val   = int'(ro);
        end
        seen[ro] = 1;
        n++;
        if (int'(idx) > imax) imax = int'(idx);
      end
    end

    initial begin
      wait (per_done);
      check($sformatf("period_len_w%0d", w), first_ret, (1 << w) - 1);
      check($sformatf("period_rep_w%0d", w), rep_val, 1);
      check($sformatf("period_zero_w%0d", w), zero_seen, 0);
      check($sformatf("period_idxmax_w%0d", w), imax, 2);
    end
  end

  initial begin
    wait (per_run);
    repeat (65540) @(negedge clk);
    per_done = 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int warm_ro [5] = '{1, 2, 4, 9, 3};
  int warm_v  [5] = '{0, 0, 0, 1, 1};
  int t1_seq  [8] = '{1, 2, 4, 9, 3, 6, 13, 10};
  int m_st, m_wleft;
  bit m_valid;

  initial begin
    reset = 1; per_reset = 1;
    a_seed = 0; a_load = 0; a_req = 0;
    b_seed = 0; b_load = 0; b_req = 0;
    c_seed = 0; c_load = 0; c_req = 1;
    d_seed = 0; d_load = 0; d_req = 0;
    repeat (2) @(negedge clk);
    check("rst_a_ro", a_ro, 1);
    check("rst_a_valid", a_v, 0);
    check("rst_c_ro", c_ro, 1);
    check("rst_d_ro", d_ro, 8'h5A);
    check("rst_d_valid", d_v, 0);
    reset = 0; per_reset = 0; per_run = 1;

    // Warm-up with Req held high
    for (int k = 0; k < 5; k++) begin
      check($sformatf("warm_ro%0d", k), c_ro, warm_ro[k]);
      check($sformatf("warm_v%0d", k), c_v, warm_v[k]);
      if (k == 4) c_req = 0;
      @(negedge clk);
    end
    check("warm_hold", c_ro, 3);

    // Single-step sequence and index folding into 3 ways
    a_seed = 1; a_load = 1;
    @(negedge clk);
    a_load = 0;
    check("t1_load_ro", a_ro, 1);
    check("t1_load_v", a_v, 0);
    a_req = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t1_ro%0d", k), a_ro, t1_seq[k]);
      check($sformatf("t1_idx%0d", k), a_idx, ref_idx(t1_seq[k], 2, 3));
      check($sformatf("t1_v%0d", k), a_v, 1);
    end

    // Load and Req together: seed wins, Valid drops
    a_seed = 5; a_load = 1;
    @(negedge clk);
    a_load = 0;
    check("ldreq_ro", a_ro, 5);
    check("ldreq_v", a_v, 0);
    @(negedge clk);
    check("ldreq_run_ro", a_ro, 5);
    check("ldreq_run_v", a_v, 1);
    @(negedge clk);
    a_req = 0;
    check("ldreq_step", a_ro, 4'hB);
    a_seed = 0; a_load = 1;
    @(negedge clk);
    a_load = 0;
    check("zero_seed", a_ro, 1);

    // Two steps per accepted request
    b_seed = 1; b_load = 1;
    @(negedge clk);
    b_load = 0;
    @(negedge clk);
    check("t2_start", b_ro, 1);
    check("t2_start_v", b_v, 1);
    b_req = 1;
    @(negedge clk);
    b_req = 0;
    check("t2_first", b_ro, 4);
    check("t2_first_idx", b_idx, 0);
    repeat (2) @(negedge clk);
    check("t2_hold", b_ro, 4);
    b_req = 1;
    @(negedge clk);
    b_req = 0;
    check("t2_second", b_ro, 3);
    check("t2_second_idx", b_idx, 3);

    // Randomized run against the reference model
    d_seed = 8'h33; d_load = 1; d_req = 0;
    m_st = 8'h33; m_valid = 0; m_wleft = 4;
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      check("rand_ro", d_ro, m_st);
      check("rand_v", d_v, m_valid);
      check("rand_idx", d_idx, ref_idx(m_st, 3, 5));
      d_load = ($urandom_range(0, 24) == 0);
      d_seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      d_req  = 1'($urandom_range(0, 1));
      if (d_load) begin
        m_st = (d_seed == 0) ? 1 : int'(d_seed);
        m_valid = 0;
        m_wleft = 4;
      end else if (!m_valid) begin
        m_st = ref_step(8, m_st);
        m_wleft--;
        if (m_wleft == 0) m_valid = 1;
      end else if (d_req) begin
        for (int s = 0; s < 3; s++) m_st = ref_step(8, m_st);
      end
      @(negedge clk);
    end
    d_load = 0; d_req = 0;

    // Asynchronous reset mid-warm-up, observed before the next clock edge
    c_seed = 7; c_load = 1;
    @(negedge clk);
    c_load = 0;
    @(negedge clk);
    check("pre_rst_c_ro", c_ro, 4'hF);
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("async_rst_c_ro", c_ro, 1);
    check("async_rst_c_v", c_v, 0);
    check("async_rst_b_ro", b_ro, 1);
    @(negedge clk);
    reset = 0;

    wait (per_done);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
Parametrised Fibonacci LFSR random source for cache random-replacement victim selection. It generalises the fixed-width LFSR to widths 3..16 and advances a programmable number of steps per accepted request. It adds zero-seed lock-up protection, a post-seed warm-up phase, and a valid/request handshake. It also folds the state into a victim way index bounded by NUMWAYS, which need not be a power of two.

Parameters:
WIDTH, 8, LFSR state width; legal range 3..16; any other value is an elaboration error.
STEPS, 1, LFSR single-steps applied per accepted request; legal range 1..WIDTH.
WARMUP, 4, free-running steps after reset or Load before Valid asserts; 0 means none.
NUMWAYS, 4, number of cache ways; legal range 2..2^WIDTH.
RESET_SEED, 1, state value on reset; must be nonzero.
IDXW, $clog2(NUMWAYS), derived index width; not overridden.

Ports:
clk  in  1  clock; all flops rising edge.
reset  in  1  asynchronous, active-high reset.
Seed  in  WIDTH  seed value, sampled when Load=1.
Load  in  1  load Seed and restart warm-up.
Req  in  1  consumer requests advance to the next random value.
Valid  out  1  RandOut/Index are usable; a request is accepted when Req&&Valid.
RandOut  out  WIDTH  current LFSR state.
Index  out  IDXW  victim way, always < NUMWAYS.

Behaviour:
- Reset (async): state=RESET_SEED, FSM=WARMUP, warm-up count=0, Valid=0.
- Single step: next = {s[WIDTH-2:0], ^(s & TAPS[WIDTH])}. Tap bits are 0-indexed:
  - 3:{2,1}, 4:{3,2}, 5:{4,2}, 6:{5,4}, 7:{6,5}
  - 8:{7,5,4,3}, 9:{8,4}, 10:{9,6}, 11:{10,8}
  - 12:{11,5,3,0}, 13:{12,3,2,0}, 14:{13,4,2,0}
  - 15:{14,13}, 16:{15,14,12,3}
  - Every width is maximal length, period 2^WIDTH-1.
- Lock-up guard: an all-zero state is never held. A zero Seed loads as 1. A computed all-zero next state is replaced by 1 (defensive).
- FSM WARMUP:
  - State advances one single step per cycle and Valid=0.
  - After WARMUP cycles the FSM goes to RUN.
  - With WARMUP=0 the FSM goes to RUN on the first edge after reset or Load.
  - A counter of $clog2(WARMUP+1) bits tracks the count.
- FSM RUN:
  - Valid=1.
  - Req&&Valid: state advances STEPS single steps (unrolled combinationally), visible the next cycle.
  - Otherwise state holds.
- Load (any state): next cycle state=Seed (or 1 if Seed=0), FSM=WARMUP, count=0, Valid=0.
  - Load has priority over Req and over warm-up stepping.
  - Load during WARMUP restarts the warm-up.
- Req while Valid=0 is ignored; no queueing.
- Index: i = RandOut[IDXW-1:0]; Index = (i>=NUMWAYS) ? i-NUMWAYS : i.
  - A single subtraction suffices because NUMWAYS > 2^(IDXW-1).
  - For power-of-two NUMWAYS, Index = i.
  - Index is combinational from state; 0-cycle latency.
- Outputs are registered state or pure functions of it; no combinational path from Req or Load to any output.
- Reset asserted mid-warm-up or mid-run: immediate return to the reset values; any pending request is lost.

Decomposition:
- Package lfsr_pkg holds:
  - function lfsr_taps(width) returning a 16-bit tap mask;
  - typedef enum {WARMUP, RUN} lfsr_state_t;
  - MIN_WIDTH=3 and MAX_WIDTH=16.
- Sub-module lfsr_step: combinational one-step next-state with zero guard, parametrised by WIDTH. It is instantiated in a generate chain STEPS deep for the request path; step 0 is reused for warm-up.

Test Plan:
1. WIDTH=4, WARMUP=0, Load Seed=0x1, then Req held high -> RandOut = 0x1, 0x2, 0x4, 0x9, 0x3, 0x6, 0xD, 0xA, with one value per cycle.
2. WIDTH=4, STEPS=2, WARMUP=0, Seed=0x1, Req pulsed twice -> RandOut 0x1 -> 0x4 -> 0x3; state holds between pulses.
3. WIDTH=4, WARMUP=3, reset released -> Valid low for cycles 1-3 while RandOut steps 0x1 -> 0x2 -> 0x4 -> 0x9; Valid high from cycle 4; Req during warm-up has no extra effect.
4. Load Seed=0 -> RandOut=0x1 next cycle. For each WIDTH 3..16, 2^WIDTH-1 accepted requests from seed 1 return to 1 with no earlier repeat and no all-zero state.
5. WIDTH=4, NUMWAYS=3, RandOut=0x3 -> Index=0; RandOut=0xD -> Index=1; RandOut=0xA -> Index=2; Index never reaches 3 across a full period.
6. Load and Req asserted together in RUN -> Seed wins and Valid drops. Async reset asserted mid-warm-up -> RandOut=RESET_SEED and Valid=0 immediately, without waiting for a clock edge.
